// File: rtl/dmcache_pkg.sv
// Shared constants for the direct-mapped cache controller: default geometry,
// FSM state encodings and a saturating counter helper.
package dmcache_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_IDX_W  = 3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEM_RD = 2'd1;
    localparam logic [1:0] ST_MEM_WR = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/dmcache_if.sv
// CPU request/response, backing-memory and statistics signals of the cache controller.
// master = CPU/memory environment side, slave = controller side.
interface dmcache_if
    import dmcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              flush;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    modport master (
        output flush, req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );

    modport slave (
        input  flush, req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
        output req_ready, resp_valid, resp_hit, resp_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dmcache_tag_array.sv
// Valid/tag/data storage: one async lookup port, one write port (sets valid), flush clears all valid.
// Tag and data have no reset; only the valid bits gate hits.
module dmcache_tag_array #(
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_vld_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_dat_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_dat_i
);
    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_dat_i;
        end
    end

    assign rd_vld_o = valid_q[rd_idx_i];
    assign rd_tag_o = tag_q[rd_idx_i];
    assign rd_dat_o = data_q[rd_idx_i];
endmodule

// File: rtl/dmcache_ctrl.sv
// Direct-mapped write-through, no-write-allocate cache controller; read hit responds next cycle,
// misses/writes wait for mem_ack then respond; req_ready only in IDLE without flush.
module dmcache_ctrl
    import dmcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input logic      clk,
    input logic      rst_n,
    dmcache_if.slave bus
);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [1:0]        state_q, state_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic [15:0]       miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              lk_vld;
    logic [TAG_W-1:0]  lk_tag;
    logic [DATA_W-1:0] lk_dat;
    logic              lookup_hit;
    logic              in_idle;
    logic              accept;
    logic              fill;
    logic              flush_go;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_dat;

    assign req_idx    = bus.req_addr[IDX_W-1:0];
    assign req_tag    = bus.req_addr[ADDR_W-1:IDX_W];
    assign lookup_hit = lk_vld && (lk_tag == req_tag);
    assign in_idle    = (state_q == ST_IDLE);
    assign accept     = bus.req_valid && in_idle && !bus.flush;
    assign fill       = (state_q == ST_MEM_RD) && bus.mem_ack;
    assign flush_go   = in_idle && bus.flush;

    // Single write port shared by write-hit update (at acceptance) and read-miss refill.
    assign wr_en  = (accept && bus.req_we && lookup_hit) || fill;
    assign wr_idx = fill ? mem_addr_q[IDX_W-1:0]      : req_idx;
    assign wr_tag = fill ? mem_addr_q[ADDR_W-1:IDX_W] : req_tag;
    assign wr_dat = fill ? bus.mem_rdata               : bus.req_wdata;

    dmcache_tag_array #(
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_go),
        .rd_idx_i (req_idx),
        .rd_vld_o (lk_vld),
        .rd_tag_o (lk_tag),
        .rd_dat_o (lk_dat),
        .wr_en_i  (wr_en),
        .wr_idx_i (wr_idx),
        .wr_tag_i (wr_tag),
        .wr_dat_i (wr_dat)
    );

    always_comb begin
        state_d     = state_q;
        hit_d       = hit_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    hit_d = lookup_hit;
                    if (!bus.req_we && lookup_hit) begin
                        state_d = ST_RESP;
                        rdata_d = lk_dat;
                    end else begin
                        state_d     = bus.req_we ? ST_MEM_WR : ST_MEM_RD;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_we;
                        mem_addr_d  = bus.req_addr;
                        mem_wdata_d = bus.req_wdata;
                    end
                end
            end
            ST_MEM_RD: begin
                if (bus.mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    rdata_d   = bus.mem_rdata;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (hit_q) begin
                    hit_cnt_d = sat_inc16(hit_cnt_q);
                end else begin
                    miss_cnt_d = sat_inc16(miss_cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hit_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hit_q       <= hit_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.req_ready  = in_idle && !bus.flush;
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_hit   = (state_q == ST_RESP) && hit_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_cnt    = hit_cnt_q;
    assign bus.miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_dmcache_ctrl.sv
// Transaction-level cache model drives per-cycle expectations; one negedge process compares them.
`timescale 1ns/1ps
module tb_dmcache_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IW = 3;
    localparam int LINES = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmcache_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    dmcache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    bit         m_valid [LINES];
    logic [4:0] m_tag   [LINES];
    logic [7:0] m_data  [LINES];
    int         m_hits;
    int         m_misses;

    bit         chk_en = 1'b0;
    logic       e_ready, e_mem_req, e_mem_we, e_resp_valid, e_resp_hit;
    logic [7:0] e_mem_addr, e_mem_wdata, e_rdata;

    int         mreq_total = 0;
    logic       last_resp_hit;
    logic       last_mem_we;
    logic [7:0] last_mem_addr, last_mem_wdata;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("mem_req", 32'(bus.mem_req), 32'(e_mem_req));
            if (e_mem_req) begin
                chk("mem_we", 32'(bus.mem_we), 32'(e_mem_we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e_mem_addr));
                if (e_mem_we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mem_wdata));
            end
            chk("resp_valid", 32'(bus.resp_valid), 32'(e_resp_valid));
            if (e_resp_valid) chk("resp_hit", 32'(bus.resp_hit), 32'(e_resp_hit));
            chk("resp_rdata", 32'(bus.resp_rdata), 32'(e_rdata));
            chk("hit_cnt", 32'(bus.hit_cnt), 32'(m_hits));
            chk("miss_cnt", 32'(bus.miss_cnt), 32'(m_misses));
            if (bus.resp_valid) last_resp_hit = bus.resp_hit;
            if (bus.mem_req) begin
                mreq_total++;
                last_mem_we    = bus.mem_we;
                last_mem_addr  = bus.mem_addr;
                last_mem_wdata = bus.mem_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        m_hits       = 0;
        m_misses     = 0;
        e_rdata      = 8'h00;
        e_mem_req    = 1'b0;
        e_mem_we     = 1'b0;
        e_resp_valid = 1'b0;
        e_resp_hit   = 1'b0;
        e_ready      = 1'b1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid = 1'b0;
            bus.req_addr  = 8'($urandom);
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = 8'($urandom);
            e_ready       = 1'b1;
            tick();
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush     = 1'b1;
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom);
        e_ready       = 1'b0;
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        e_ready       = 1'b1;
    endtask

    // One CPU request; lat = mem_req cycles incl. ack cycle; flush_at/rst_at = wait cycle index (0 = none).
    task automatic txn(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                       input int lat, input logic [7:0] rd, input int flush_at, input int rst_at);
        logic [2:0] idx;
        logic [4:0] tag;
        bit         hit;
        idx = addr[2:0];
        tag = addr[7:3];
        hit = m_valid[idx] && (m_tag[idx] == tag);

        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.flush     = 1'b0;
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = 8'($urandom);
        e_ready       = 1'b1;
        e_mem_req     = 1'b0;
        e_resp_valid  = 1'b0;
        tick();

        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 8'($urandom);
        bus.mem_ack   = 1'b0;
        e_ready       = 1'b0;
        if (!we && hit) begin
            bus.mem_ack  = 1'($urandom_range(0, 1));
            e_resp_valid = 1'b1;
            e_resp_hit   = 1'b1;
            e_rdata      = m_data[idx];
            tick();
        end else begin
            e_mem_req   = 1'b1;
            e_mem_we    = we;
            e_mem_addr  = addr;
            e_mem_wdata = wd;
            if (we && hit) m_data[idx] = wd;
            for (int c = 1; c <= lat; c++) begin
                bus.mem_ack   = (c == lat);
                bus.mem_rdata = (c == lat) ? rd : 8'($urandom);
                bus.flush     = (c == flush_at);
                rst_n         = (c != rst_at);
                tick();
                if (c == rst_at) begin
                    rst_n       = 1'b1;
                    bus.mem_ack = 1'b0;
                    bus.flush   = 1'b0;
                    reset_model();
                    return;
                end
            end
            bus.flush   = 1'b0;
            bus.mem_ack = 1'($urandom_range(0, 1));
            if (!we) begin
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = rd;
                e_rdata      = rd;
            end
            e_mem_req    = 1'b0;
            e_resp_valid = 1'b1;
            e_resp_hit   = hit;
            tick();
        end
        bus.mem_ack  = 1'b0;
        e_resp_valid = 1'b0;
        e_ready      = 1'b1;
        if (hit) begin
            if (m_hits < 65535) m_hits++;
        end else begin
            if (m_misses < 65535) m_misses++;
        end
    endtask

    int         m0;
    bit         r_we;
    logic [7:0] r_addr;
    int         r_lat, r_fa, r_ra;

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        reset_model();
        e_mem_addr  = 8'h00;
        e_mem_wdata = 8'h00;
        rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
        rst_n = 1'b1;
        tick();

        // Miss then hit on 0x2A
        m0 = mreq_total;
        txn(1'b0, 8'h2A, 8'h00, 3, 8'h5C, 0, 0);
        chk("lit_miss_mreq_cycles", 32'(mreq_total - m0), 32'd3);
        chk("lit_miss_rdata", 32'(bus.resp_rdata), 32'h5C);
        chk("lit_miss_cnt1", 32'(bus.miss_cnt), 32'd1);
        chk("lit_miss_hit0", 32'(last_resp_hit), 32'd0);
        m0 = mreq_total;
        txn(1'b0, 8'h2A, 8'h00, 1, 8'h00, 0, 0);
        chk("lit_hit_no_mreq", 32'(mreq_total - m0), 32'd0);
        chk("lit_hit_rdata", 32'(bus.resp_rdata), 32'h5C);
        chk("lit_hit_cnt1", 32'(bus.hit_cnt), 32'd1);
        chk("lit_hit_hit1", 32'(last_resp_hit), 32'd1);

        // Conflict eviction on index 2
        txn(1'b0, 8'h32, 8'h00, 2, 8'h11, 0, 0);
        chk("lit_evict_rdata", 32'(bus.resp_rdata), 32'h11);
        txn(1'b0, 8'h2A, 8'h00, 2, 8'h5C, 0, 0);
        chk("lit_evicted_miss", 32'(last_resp_hit), 32'd0);
        chk("lit_miss_cnt3", 32'(bus.miss_cnt), 32'd3);
        txn(1'b0, 8'h32, 8'h00, 1, 8'h11, 0, 0);

        // Write-through hit, then no-write-allocate miss
        txn(1'b1, 8'h32, 8'hAB, 2, 8'h00, 0, 0);
        chk("lit_wr_hit", 32'(last_resp_hit), 32'd1);
        chk("lit_wr_we", 32'(last_mem_we), 32'd1);
        chk("lit_wr_addr", 32'(last_mem_addr), 32'h32);
        chk("lit_wr_wdata", 32'(last_mem_wdata), 32'hAB);
        txn(1'b0, 8'h32, 8'h00, 1, 8'h00, 0, 0);
        chk("lit_rd_after_wr_hit", 32'(last_resp_hit), 32'd1);
        chk("lit_rd_after_wr_data", 32'(bus.resp_rdata), 32'hAB);
        txn(1'b1, 8'h40, 8'h77, 1, 8'h00, 0, 0);
        chk("lit_wr_miss", 32'(last_resp_hit), 32'd0);
        txn(1'b0, 8'h40, 8'h00, 2, 8'h99, 0, 0);
        chk("lit_no_alloc_miss", 32'(last_resp_hit), 32'd0);

        // Flush in IDLE, then flush ignored during a refill
        do_flush();
        txn(1'b0, 8'h32, 8'h00, 1, 8'hAB, 0, 0);
        chk("lit_flush_miss", 32'(last_resp_hit), 32'd0);
        txn(1'b0, 8'h18, 8'h00, 4, 8'h3C, 2, 0);
        txn(1'b0, 8'h18, 8'h00, 1, 8'h00, 0, 0);
        chk("lit_flush_ignored_hit", 32'(last_resp_hit), 32'd1);
        chk("lit_flush_ignored_data", 32'(bus.resp_rdata), 32'h3C);

        // Reset while waiting on a refill
        txn(1'b0, 8'h55, 8'h00, 5, 8'hEE, 0, 2);
        chk("lit_rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
        gap(1);
        txn(1'b0, 8'h55, 8'h00, 1, 8'hEE, 0, 0);
        chk("lit_rst_then_miss", 32'(last_resp_hit), 32'd0);

        for (int i = 0; i < 250; i++) begin
            r_we   = ($urandom_range(0, 9) < 3);
            r_addr = {3'b000, 2'($urandom_range(0, 3)), 3'($urandom)};
            r_lat  = $urandom_range(1, 4);
            r_fa   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, r_lat) : 0;
            r_ra   = ($urandom_range(0, 39) == 0 && r_lat > 1) ? $urandom_range(1, r_lat - 1) : 0;
            if ($urandom_range(0, 19) == 0) do_flush();
            txn(r_we, r_addr, 8'($urandom), r_lat, 8'($urandom), r_fa, r_ra);
            gap($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
